// File: rtl/phase_clock_gen.sv
// phi1/phi2 phase generator driven from clk through clock-enable counters, with
// a runtime divider, cycle-boundary start/stop and per-cycle phi2-high stretching.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | generator stopped, phi2 low, waiting for run
// S_RUN     | normal quarters q0..q3 (phi2 high in q2/q3)
// S_STRETCH | extra phi2-high quarters after q3 while xcnt counts down
module phase_clock_gen #(
    parameter int DIV_W          = 8,
    parameter int STRETCH_W      = 4,
    parameter int STARTUP_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic [DIV_W-1:0]     div,
    input  logic                 stretch_req,
    input  logic [STRETCH_W-1:0] stretch_len,
    output logic                 phi2,
    output logic                 phi1,
    output logic                 phi2_rise,
    output logic                 phi2_fall,
    output logic                 fclk_en,
    output logic                 stretch_ack,
    output logic                 clock_running
);
    localparam int CYC_W = $clog2(STARTUP_CYCLES + 1);
    localparam logic [CYC_W-1:0] CYC_MAX = CYC_W'(STARTUP_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_STRETCH
    } state_t;

    state_t                 r_state, w_state_nx;
    logic [DIV_W-1:0]       r_qcnt, w_qcnt_nx;
    logic [DIV_W-1:0]       r_div_act, w_div_act_nx;
    logic [1:0]             r_q, w_q_nx;
    logic [STRETCH_W-1:0]   r_xcnt, w_xcnt_nx;
    logic                   r_stretch_pend, w_stretch_pend_nx;
    logic [CYC_W-1:0]       r_cyc_cnt, w_cyc_cnt_nx;

    logic r_phi2, r_phi1, r_rise, r_fall, r_fclk, r_ack, r_running;
    logic w_phi2_nx, w_rise_nx, w_fall_nx, w_fclk_nx, w_ack_nx, w_running_nx;
    logic w_qend, w_boundary;

    always_comb begin
        w_state_nx        = r_state;
        w_qcnt_nx         = r_qcnt;
        w_div_act_nx      = r_div_act;
        w_q_nx            = r_q;
        w_xcnt_nx         = r_xcnt;
        w_stretch_pend_nx = r_stretch_pend;
        w_cyc_cnt_nx      = r_cyc_cnt;
        w_phi2_nx         = 1'b0;
        w_rise_nx         = 1'b0;
        w_fall_nx         = 1'b0;
        w_fclk_nx         = 1'b0;
        w_ack_nx          = 1'b0;
        w_running_nx      = r_running;
        w_qend            = (r_qcnt == r_div_act);
        w_boundary        = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cyc_cnt_nx = '0;
                w_running_nx = 1'b0;
                if (run) begin
                    w_state_nx   = S_RUN;
                    w_div_act_nx = div;
                    w_q_nx       = 2'd0;
                    w_qcnt_nx    = '0;
                    w_fclk_nx    = 1'b1;
                end
            end
            S_RUN: begin
                w_phi2_nx = r_q[1];
                if (w_qend) begin
                    w_qcnt_nx = '0;
                    w_fclk_nx = 1'b1;
                    if (r_q == 2'd3) begin
                        if (r_stretch_pend && (r_xcnt != '0)) begin
                            w_state_nx = S_STRETCH;
                            w_phi2_nx  = 1'b1;
                        end else begin
                            w_boundary = 1'b1;
                        end
                    end else begin
                        w_q_nx    = r_q + 2'd1;
                        w_phi2_nx = (r_q != 2'd0);
                        // stretch request only counts in the clock of the q1->q2 rise
                        if (r_q == 2'd1) begin
                            w_rise_nx         = 1'b1;
                            w_stretch_pend_nx = stretch_req;
                            w_xcnt_nx         = stretch_len;
                        end
                    end
                end else begin
                    w_qcnt_nx = r_qcnt + DIV_W'(1);
                end
            end
            S_STRETCH: begin
                w_phi2_nx = 1'b1;
                if (w_qend) begin
                    w_qcnt_nx = '0;
                    w_fclk_nx = 1'b1;
                    w_xcnt_nx = r_xcnt - STRETCH_W'(1);
                    if (r_xcnt == STRETCH_W'(1))
                        w_boundary = 1'b1;
                end else begin
                    w_qcnt_nx = r_qcnt + DIV_W'(1);
                end
            end
            default: w_state_nx = S_IDLE;
        endcase

        if (w_boundary) begin
            w_phi2_nx         = 1'b0;
            w_fall_nx         = 1'b1;
            w_ack_nx          = r_stretch_pend;
            w_stretch_pend_nx = 1'b0;
            w_q_nx            = 2'd0;
            w_qcnt_nx         = '0;
            if (r_cyc_cnt < CYC_MAX)
                w_cyc_cnt_nx = r_cyc_cnt + CYC_W'(1);
            if (w_cyc_cnt_nx == CYC_MAX)
                w_running_nx = 1'b1;
            if (run) begin
                w_state_nx   = S_RUN;
                w_div_act_nx = div;
                w_fclk_nx    = 1'b1;
            end else begin
                w_state_nx   = S_IDLE;
                w_fclk_nx    = 1'b0;
                w_cyc_cnt_nx = '0;
                w_running_nx = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_qcnt         <= '0;
            r_div_act      <= '0;
            r_q            <= 2'd0;
            r_xcnt         <= '0;
            r_stretch_pend <= 1'b0;
            r_cyc_cnt      <= '0;
            r_phi2         <= 1'b0;
            r_phi1         <= 1'b1;
            r_rise         <= 1'b0;
            r_fall         <= 1'b0;
            r_fclk         <= 1'b0;
            r_ack          <= 1'b0;
            r_running      <= 1'b0;
        end else begin
            r_state        <= w_state_nx;
            r_qcnt         <= w_qcnt_nx;
            r_div_act      <= w_div_act_nx;
            r_q            <= w_q_nx;
            r_xcnt         <= w_xcnt_nx;
            r_stretch_pend <= w_stretch_pend_nx;
            r_cyc_cnt      <= w_cyc_cnt_nx;
            r_phi2         <= w_phi2_nx;
            r_phi1         <= ~w_phi2_nx;
            r_rise         <= w_rise_nx;
            r_fall         <= w_fall_nx;
            r_fclk         <= w_fclk_nx;
            r_ack          <= w_ack_nx;
            r_running      <= w_running_nx;
        end
    end

    assign phi2          = r_phi2;
    assign phi1          = r_phi1;
    assign phi2_rise     = r_rise;
    assign phi2_fall     = r_fall;
    assign fclk_en       = r_fclk;
    assign stretch_ack   = r_ack;
    assign clock_running = r_running;

endmodule
